led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_mode_ctrl.sv | 113 +++++++++++
 tb/tb_led_mode_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - debounced four-button LED pattern/speed/auto selector
// Buttons: up/dn step mode 0..9 with hold auto-repeat, speed steps mode_hz 0..4, auto toggles.
module led_mode_ctrl #(
  parameter logic [19:0] DEB_CYCLES    = 20'd500000,
  parameter logic [24:0] HOLD_CYCLES   = 25'd25000000,
  parameter logic [24:0] REPEAT_CYCLES = 25'd5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_speed,
  input  logic       btn_auto,
  output logic [3:0] mode,
  output logic [2:0] mode_hz,
  output logic       auto,
  output logic       chg
);
  localparam logic [19:0] DEB_LAST = (DEB_CYCLES == 20'd0) ? 20'd0 : DEB_CYCLES - 20'd1;
  localparam logic [24:0] REP_LAST = (REPEAT_CYCLES == 25'd0) ? 25'd0 : REPEAT_CYCLES - 25'd1;

  // bit order everywhere: 0 up, 1 dn, 2 speed, 3 auto
  logic [3:0]  raw, sync1, sync2, deb, deb_d, press;
  logic [19:0] deb_cnt [4];
  logic [24:0] hold_cnt [2];
  logic [24:0] rep_cnt [2];
  logic [1:0]  step;
  logic        up_ev, dn_ev;
  logic [3:0]  mode_nxt;
  logic [2:0]  hz_nxt;
  logic        auto_nxt;

  assign raw = {btn_auto, btn_speed, btn_dn, btn_up};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  // hold_cnt is the hold-cycle index (press cycle = 0), saturating at HOLD_CYCLES;
  // rep_cnt then free-runs modulo REPEAT_CYCLES to pace the repeat steps.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset || !deb_d[i]) begin
        hold_cnt[i] <= '0;
        rep_cnt[i]  <= '0;
      end else if (hold_cnt[i] < HOLD_CYCLES) begin
        hold_cnt[i] <= hold_cnt[i] + 25'd1;
      end else if (rep_cnt[i] >= REP_LAST) begin
        rep_cnt[i] <= '0;
      end else begin
        rep_cnt[i] <= rep_cnt[i] + 25'd1;
      end
    end
  end

  assign step[0] = deb_d[0] && !press[0] && !deb_d[1] &&
                   (hold_cnt[0] == HOLD_CYCLES) && (rep_cnt[0] == 25'd0);
  assign step[1] = deb_d[1] && !press[1] && !deb_d[0] &&
                   (hold_cnt[1] == HOLD_CYCLES) && (rep_cnt[1] == 25'd0);

  always_comb begin
    up_ev    = press[0] | step[0];
    dn_ev    = press[1] | step[1];
    mode_nxt = mode;
    hz_nxt   = mode_hz;
    auto_nxt = auto ^ press[3];
    // mode moves only if auto was off before this cycle's toggle
    if (!auto && up_ev && !dn_ev) begin
      mode_nxt = (mode >= 4'd9) ? 4'd0 : mode + 4'd1;
    end else if (!auto && dn_ev && !up_ev) begin
      mode_nxt = (mode == 4'd0 || mode > 4'd9) ? 4'd9 : mode - 4'd1;
    end
    if (press[2]) begin
      hz_nxt = (mode_hz >= 3'd4) ? 3'd0 : mode_hz + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= 4'd0;
      mode_hz <= 3'd0;
      auto    <= 1'b0;
      chg     <= 1'b0;
    end else begin
      mode    <= mode_nxt;
      mode_hz <= hz_nxt;
      auto    <= auto_nxt;
      chg     <= (mode_nxt != mode) || (hz_nxt != mode_hz) || (auto_nxt != auto);
    end
  end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - table, directed and randomized checks for led_mode_ctrl
module tb_led_mode_ctrl;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int MAXE = 16384;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_dn = 1'b0, btn_speed = 1'b0, btn_auto = 1'b0;
  logic [3:0] mode;
  logic [2:0] mode_hz;
  logic       auto, chg;

  int errors = 0;
  int checks = 0;

  led_mode_ctrl #(
    .DEB_CYCLES(20'd4), .HOLD_CYCLES(25'd20), .REPEAT_CYCLES(25'd5)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
    .btn_speed(btn_speed), .btn_auto(btn_auto),
    .mode(mode), .mode_hz(mode_hz), .auto(auto), .chg(chg)
  );

  always #5 clk = ~clk;

  // Reference model: history of raw samples and debounced run lengths per edge.
  logic [3:0] raw_at [0:MAXE-1];
  int         run_at [0:MAXE-1][4];
  int         n = -1;
  int         last_rst = 0;
  logic [3:0] dstate = '0;
  int         run [4];
  int         exp_mode = 0, exp_hz = 0, exp_auto = 0, exp_chg = 0;
  bit         model_ok = 0;

  function automatic logic syn_at(input int m, input int b);
    if (m - 2 > last_rst && m - 2 >= 0) return raw_at[m-2][b];
    return 1'b0;
  endfunction

  task automatic model_update();
    int  rb [4];
    bit  ev_up, ev_dn, ev_sp, ev_au, all_diff;
    int  nm, nh, na;
    n++;
    if (n >= MAXE) begin
      $display("FAIL model history overflow at edge %0d", n);
      $fatal(1);
    end
    raw_at[n] = {btn_auto, btn_speed, btn_dn, btn_up};
    if (reset) begin
      last_rst = n;
      dstate   = '0;
      for (int b = 0; b < 4; b++) begin run[b] = 0; run_at[n][b] = 0; end
      exp_mode = 0; exp_hz = 0; exp_auto = 0; exp_chg = 0;
      model_ok = 1;
      return;
    end
    for (int b = 0; b < 4; b++) rb[b] = (n - 2 >= last_rst) ? run_at[n-2][b] : 0;
    ev_sp = (rb[2] == 1);
    ev_au = (rb[3] == 1);
    ev_up = (rb[0] == 1) || (rb[0] - 1 >= HOLD && (rb[0] - 1 - HOLD) % REP == 0 && rb[1] == 0);
    ev_dn = (rb[1] == 1) || (rb[1] - 1 >= HOLD && (rb[1] - 1 - HOLD) % REP == 0 && rb[0] == 0);
    nm = exp_mode; nh = exp_hz; na = exp_auto ^ int'(ev_au);
    if (exp_auto == 0) begin
      if (ev_up && !ev_dn) nm = (nm + 1) % 10;
      else if (ev_dn && !ev_up) nm = (nm + 9) % 10;
    end
    if (ev_sp) nh = (nh + 1) % 5;
    exp_chg  = (nm != exp_mode || nh != exp_hz || na != exp_auto) ? 1 : 0;
    exp_mode = nm; exp_hz = nh; exp_auto = na;
    for (int b = 0; b < 4; b++) begin
      if (n - DEB + 1 > last_rst) begin
        all_diff = 1;
        for (int m = n - DEB + 1; m <= n; m++) if (syn_at(m, b) == dstate[b]) all_diff = 0;
        if (all_diff) dstate[b] = ~dstate[b];
      end
      run[b] = dstate[b] ? run[b] + 1 : 0;
      run_at[n][b] = run[b];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (model_ok) begin
      checks++;
      if (mode != exp_mode || mode_hz != exp_hz || auto != exp_auto || chg != exp_chg) begin
        errors++;
        $display("FAIL model edge %0d: mode=%0d hz=%0d auto=%0d chg=%0d required %0d %0d %0d %0d",
                 n, mode, mode_hz, auto, chg, exp_mode, exp_hz, exp_auto, exp_chg);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, expv);
    end
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btn_auto, btn_speed, btn_dn, btn_up} = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int         chg_edges[$];
  logic [3:0] mode_at [0:127];

  task automatic run_pat(input logic [3:0] btn, input logic [127:0] pat, input int total);
    chg_edges.delete();
    for (int i = 0; i < total; i++) begin
      set_btns(pat[i] ? btn : 4'b0000);
      tick();
      mode_at[i] = mode;
      if (chg) chg_edges.push_back(i);
    end
    set_btns(4'b0000);
    repeat (12) tick();
  endtask

  task automatic cmp_edges(input string name, input int exp_e[$]);
    chk({name, " pulse count"}, chg_edges.size(), exp_e.size());
    for (int i = 0; i < exp_e.size() && i < chg_edges.size(); i++)
      chk({name, " pulse edge"}, chg_edges[i], exp_e[i]);
  endtask

  typedef struct packed {
    logic [3:0] btn;
    logic [3:0] mode;
    logic [2:0] hz;
    logic       au;
    logic       chg;
  } vec_t;

  vec_t vt [20];

  initial begin
    int         exp_e[$];
    int         seen;
    int         dur [4];
    logic [3:0] lvl;

    vt[0]  = '{4'b0001, 4'd1, 3'd0, 1'b0, 1'b1};
    vt[1]  = '{4'b0001, 4'd2, 3'd0, 1'b0, 1'b1};
    vt[2]  = '{4'b0010, 4'd1, 3'd0, 1'b0, 1'b1};
    vt[3]  = '{4'b0010, 4'd0, 3'd0, 1'b0, 1'b1};
    vt[4]  = '{4'b0010, 4'd9, 3'd0, 1'b0, 1'b1};
    vt[5]  = '{4'b0001, 4'd0, 3'd0, 1'b0, 1'b1};
    vt[6]  = '{4'b0100, 4'd0, 3'd1, 1'b0, 1'b1};
    vt[7]  = '{4'b0100, 4'd0, 3'd2, 1'b0, 1'b1};
    vt[8]  = '{4'b0100, 4'd0, 3'd3, 1'b0, 1'b1};
    vt[9]  = '{4'b0100, 4'd0, 3'd4, 1'b0, 1'b1};
    vt[10] = '{4'b0100, 4'd0, 3'd0, 1'b0, 1'b1};
    vt[11] = '{4'b0011, 4'd0, 3'd0, 1'b0, 1'b0};
    vt[12] = '{4'b1000, 4'd0, 3'd0, 1'b1, 1'b1};
    vt[13] = '{4'b0001, 4'd0, 3'd0, 1'b1, 1'b0};
    vt[14] = '{4'b0010, 4'd0, 3'd0, 1'b1, 1'b0};
    vt[15] = '{4'b1001, 4'd0, 3'd0, 1'b0, 1'b1};
    vt[16] = '{4'b1001, 4'd1, 3'd0, 1'b1, 1'b1};
    vt[17] = '{4'b1000, 4'd1, 3'd0, 1'b0, 1'b1};
    vt[18] = '{4'b0101, 4'd2, 3'd1, 1'b0, 1'b1};
    vt[19] = '{4'b0010, 4'd1, 3'd1, 1'b0, 1'b1};

    do_reset();
    chk("reset mode", int'(mode), 0);
    chk("reset mode_hz", int'(mode_hz), 0);
    chk("reset auto", int'(auto), 0);
    chk("reset chg", int'(chg), 0);

    // clean press: change exactly 7 edges after first high sample
    run_pat(4'b0001, 128'h3FF, 14);
    exp_e = '{7};
    cmp_edges("clean press", exp_e);
    chk("clean press mode before", int'(mode_at[6]), 0);
    chk("clean press mode at", int'(mode_at[7]), 1);

    // bounce: high 2, low 1, then stable high from edge 3
    run_pat(4'b0001, 128'hFFFFB, 30);
    exp_e = '{10};
    cmp_edges("bounce", exp_e);
    chk("bounce mode before", int'(mode_at[9]), 1);
    chk("bounce mode at", int'(mode_at[10]), 2);

    // held through hold cycle 42: steps at hold cycles 0,20,25,30,35,40
    do_reset();
    run_pat(4'b0001, (128'd1 << 43) - 128'd1, 70);
    exp_e = '{7, 27, 32, 37, 42, 47};
    cmp_edges("auto-repeat", exp_e);
    chk("auto-repeat final mode", int'(mode_at[69]), 6);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_btns(vt[i].btn);
      repeat (DEB + 4) tick();
      chk($sformatf("vec%0d mode", i), int'(mode), int'(vt[i].mode));
      chk($sformatf("vec%0d mode_hz", i), int'(mode_hz), int'(vt[i].hz));
      chk($sformatf("vec%0d auto", i), int'(auto), int'(vt[i].au));
      chk($sformatf("vec%0d chg", i), int'(chg), int'(vt[i].chg));
      set_btns(4'b0000);
      repeat (12) tick();
    end

    // reset inside the debounce window discards the partial press
    set_btns(4'b0001);
    repeat (3) tick();
    reset = 1'b1;
    set_btns(4'b0000);
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (15) begin tick(); if (chg) seen++; end
    chk("mid-debounce reset chg pulses", seen, 0);
    chk("mid-debounce reset mode", int'(mode), 0);
    chk("mid-debounce reset mode_hz", int'(mode_hz), 0);
    chk("mid-debounce reset auto", int'(auto), 0);

    // button held through reset release registers one press 7 edges later
    set_btns(4'b0001);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    run_pat(4'b0001, 128'h3FF, 14);
    exp_e = '{7};
    cmp_edges("held through reset", exp_e);
    chk("held through reset mode", int'(mode_at[7]), 1);

    for (int b = 0; b < 4; b++) dur[b] = 0;
    lvl = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (dur[b] == 0) begin
          lvl[b] = 1'($urandom_range(0, 1));
          dur[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 80));
        end
        dur[b]--;
      end
      reset = ($urandom_range(0, 499) == 0);
      set_btns(lvl);
      tick();
    end
    reset = 1'b0;
    set_btns(4'b0000);
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
